// File: rtl/mult32x32_arbiter_pkg.sv
// Shared types and constants for the round-robin front end of the 32x32
// sequential multiplier.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int OP_W     = 32;
    localparam int PROD_W   = 64;
    localparam int NREQ_DEF = 2;

    // A single requester still needs a one-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult32x32_arbiter_if.sv
// Requester-side bus: per-requester request/operands plus the shared
// grant and product response.
interface mult32x32_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
);

    logic [NREQ-1:0]      req;
    logic [NREQ*OP_W-1:0] req_a;
    logic [NREQ*OP_W-1:0] req_b;
    logic [NREQ-1:0]      gnt;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [PROD_W-1:0]    rsp_product;
    logic                 rsp_ready;

    modport master (
        output req, req_a, req_b, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req, req_a, req_b, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_product
    );

endinterface

// File: rtl/mult32x32_arbiter_rr.sv
// Round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any_req
);

    int k;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        k       = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!any_req && req[k]) begin
                any_req  = 1'b1;
                grant[k] = 1'b1;
                idx      = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/mult32x32_arbiter.sv
// Shares one sequential 32x32 multiplier between NREQ requesters: arbitrate,
// issue one start pulse, hold operands through busy, return the product.
//
//   state | meaning
//   IDLE  | arbitrate; latch winner operands/id on any request
//   ISSUE | one-cycle mul_start and gnt[owner]
//   WAIT  | operands held; capture product when mul_busy drops
//   RESP  | rsp_valid high until rsp_ready
module mult32x32_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    mult32x32_arbiter_if.slave  bus,
    output logic                mul_start,
    output logic [OP_W-1:0]     mul_a,
    output logic [OP_W-1:0]     mul_b,
    input  logic                mul_busy,
    input  logic [PROD_W-1:0]   mul_product
);

    arb_state_t        state_q, state_d;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    owner_q;
    logic [NREQ-1:0]   gnt_q;
    logic [OP_W-1:0]   op_a_q, op_b_q;
    logic [PROD_W-1:0] prod_q;

    logic [NREQ-1:0]   pick_onehot;
    logic [IDW-1:0]    pick_idx;
    logic              pick_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req     (bus.req),
        .ptr     (ptr_q),
        .grant   (pick_onehot),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any)       state_d = ISSUE;
            ISSUE:                       state_d = WAIT;
            WAIT:    if (!mul_busy)      state_d = RESP;
            RESP:    if (bus.rsp_ready)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Arbitration and operand capture happen only in IDLE, so request
    // changes later in the operation cannot disturb the multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            prod_q  <= '0;
        end else begin
            if (state_q == IDLE && pick_any) begin
                owner_q <= pick_idx;
                gnt_q   <= pick_onehot;
                op_a_q  <= bus.req_a[pick_idx*OP_W +: OP_W];
                op_b_q  <= bus.req_b[pick_idx*OP_W +: OP_W];
                ptr_q   <= (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
            end
            if (state_q == WAIT && !mul_busy)
                prod_q <= mul_product;
        end
    end

    assign mul_start       = (state_q == ISSUE);
    assign mul_a           = op_a_q;
    assign mul_b           = op_b_q;
    assign bus.gnt         = (state_q == ISSUE) ? gnt_q : '0;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = owner_q;
    assign bus.rsp_product = prod_q;

endmodule
